apb_completer_regbank: RTL and testbench
========================================

Name: apb_completer_regbank

Overview:
- APB4 completer holding NUM_REGS software-visible registers of DATA_WIDTH bits each.
- Inserts a configurable number of wait states per transfer.
- Flags pslverr for misaligned, unmapped or privilege-violating accesses.
- Sits on the far end of apb_vip_if. It is the DUT-side responder that the agent's requester drives, and the reference completer used in agent self-tests.

Parameters:
- ADDR_WIDTH, 12, paddr width, <= 32
- DATA_WIDTH, 32, data width, 8/16/32; STRB_WIDTH = DATA_WIDTH/8, LSB = log2(STRB_WIDTH)
- NUM_REGS, 16, number of registers, 1..256
- WAIT_STATES, 0, pready-low access cycles per transfer, 0..15
- PRIV_MASK, 0, NUM_REGS-bit mask; set bit = register needs pprot[0]=1
- ERR_ON_UNMAPPED, 1, 1 = pslverr on index >= NUM_REGS; 0 = read 0 / write ignored, no error

Ports:
- pclk     input   1                    APB clock
- preset_n input   1                    reset, asynchronous, active-low
- paddr    input   ADDR_WIDTH           address
- pprot    input   3                    protection; only bit0 (privileged) used
- psel     input   1                    select
- penable  input   1                    enable
- pwrite   input   1                    1 = write
- pwdata   input   DATA_WIDTH           write data
- pstrb    input   STRB_WIDTH           byte write strobes
- pready   output  1                    transfer complete
- prdata   output  DATA_WIDTH           read data
- pslverr  output  1                    error response
- reg_q    output  NUM_REGS*DATA_WIDTH  flattened register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Reset (async, preset_n=0):
  - pready=0, prdata=0, pslverr=0.
  - All registers and the wait counter = 0; FSM = IDLE.
- Decode:
  - idx = paddr[ADDR_WIDTH-1:LSB].
  - misaligned = paddr[LSB-1:0] != 0 (never true when LSB=0).
  - unmapped = idx >= NUM_REGS.
  - privfail = PRIV_MASK[idx] && !pprot[0].
  - err = misaligned | privfail | (unmapped & ERR_ON_UNMAPPED).
- FSM states: IDLE, ACCESS.
- IDLE:
  - On an edge sampling psel=1, penable=0 (setup): go to ACCESS.
  - At that same edge, latch decode, pwrite, pwdata, pstrb and load cnt=WAIT_STATES.
  - If WAIT_STATES=0, also register pready=1 plus response data, so pready is high in the first access cycle.
  - psel=1 with penable=1 in IDLE (no setup seen) is ignored; pready stays 0.
- ACCESS, while pready=0:
  - Each edge with psel=1 and penable=1 decrements cnt.
  - When cnt goes 1->0, register pready=1 and response data.
  - Total latency = WAIT_STATES pready-low access cycles, then one pready-high cycle.
- Response data, valid only while pready=1 (prdata=0 and pslverr=0 otherwise):
  - pslverr = err.
  - prdata = register[idx] for a read with no error and a mapped index; otherwise 0.
- Completion edge (psel=1, penable=1, pready=1):
  - Write with no error and a mapped index: for each byte b with pstrb[b]=1, reg[idx][8b+7:8b] = pwdata byte b. Bytes with pstrb[b]=0 are unchanged.
  - Errored or unmapped writes change nothing.
  - Clear pready, prdata and pslverr to 0; go to IDLE.
- Reads ignore pstrb.
- Back-to-back transfers: the next setup edge follows the completion edge, so pready is low for at least one cycle between transfers.
- Abort: psel=0 at any edge in ACCESS → IDLE, no register update, outputs cleared.
- Reset mid-transfer: immediate return to the reset state; any pending write is discarded.
- reg_q reflects committed writes from the cycle after the completion edge.

Test Plan:
- Reset then read idx 3 (paddr=0x00C), WAIT_STATES=0 → pready=1 in first access cycle, prdata=0x00000000, pslverr=0.
- Write 0xDEADBEEF to 0x004 with pstrb=4'b1111, then write 0x11223344 with pstrb=4'b0101, then read 0x004 → prdata=0xDE22BE44; reg_q[63:32]=0xDE22BE44.
- WAIT_STATES=3: write to 0x008 → exactly 3 access cycles with pready=0, pready=1 on the 4th; register unchanged until the completion edge.
- Errors:
  - read 0x002 → pslverr=1, prdata=0.
  - write 0x040 (idx 16, NUM_REGS=16) → pslverr=1, no register changes.
  - with ERR_ON_UNMAPPED=0, same write → pslverr=0, no change.
- PRIV_MASK=16'h0001: write 0xA5A5A5A5 to 0x000 with pprot=3'b000 → pslverr=1, reg0 stays 0; repeat with pprot=3'b001 → pslverr=0, reg0=0xA5A5A5A5.
- WAIT_STATES=2:
  - drop psel during a wait cycle of a write → no update, pready never asserted.
  - assert preset_n=0 mid-access → all outputs and registers 0 asynchronously.

Source files
------------

// File: rtl/apb_completer_regbank.sv
// APB4 completer: NUM_REGS byte-strobed registers with pslverr for misaligned, unmapped or privileged accesses.
// Latency WAIT_STATES pready-low access cycles then one pready-high cycle; the requester is held off via pready.
module apb_completer_regbank #(
   parameter int                  ADDR_WIDTH      = 12,
   parameter int                  DATA_WIDTH      = 32,
   parameter int                  NUM_REGS        = 16,
   parameter int                  WAIT_STATES     = 0,
   parameter logic [NUM_REGS-1:0] PRIV_MASK       = '0,
   parameter int                  ERR_ON_UNMAPPED = 1
) (
   input  logic                           pclk,
   input  logic                           preset_n,
   input  logic [ADDR_WIDTH-1:0]          paddr,
   input  logic [2:0]                     pprot,
   input  logic                           psel,
   input  logic                           penable,
   input  logic                           pwrite,
   input  logic [DATA_WIDTH-1:0]          pwdata,
   input  logic [DATA_WIDTH/8-1:0]        pstrb,
   output logic                           pready,
   output logic [DATA_WIDTH-1:0]          prdata,
   output logic                           pslverr,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int LSB        = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);

   typedef enum logic {S_IDLE, S_ACCESS} state_t;

   typedef struct packed {
      logic                  write;
      logic                  err;
      logic                  mapped;
      logic [ADDR_WIDTH-1:0] idx;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] strb;
   } req_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   req_t                  req_q, req_d;
   logic                  pready_q, pready_d;
   logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
   logic                  pslverr_q, pslverr_d;
   logic [DATA_WIDTH-1:0] regfile_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regfile_d [NUM_REGS];

   logic [ADDR_WIDTH-1:0] dec_idx;
   logic                  dec_mapped, dec_priv, dec_err;
   logic [ADDR_WIDTH-1:0] rd_idx;
   logic [DATA_WIDTH-1:0] rd_dat;
   logic                  prot_unused;

   assign prot_unused = ^pprot[2:1];

   always_comb begin
      dec_idx    = paddr >> LSB;
      dec_mapped = 1'b0;
      dec_priv   = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (dec_idx == ADDR_WIDTH'(i)) begin
            dec_mapped = 1'b1;
            dec_priv   = PRIV_MASK[i];
         end
      end
      dec_err = ((paddr & ALIGN_MASK) != '0) | (dec_priv & ~pprot[0]) |
                (~dec_mapped & (ERR_ON_UNMAPPED != 0));
   end

   // Zero-wait responses are built at the setup edge, so read from the live decode in IDLE.
   always_comb begin
      rd_idx = (state_q == S_IDLE) ? dec_idx : req_q.idx;
      rd_dat = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == ADDR_WIDTH'(i)) rd_dat = regfile_q[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      pready_d  = pready_q;
      prdata_d  = prdata_q;
      pslverr_d = pslverr_q;
      regfile_d = regfile_q;
      case (state_q)
         S_IDLE: begin
            if (psel && !penable) begin
               state_d = S_ACCESS;
               cnt_d   = 4'(WAIT_STATES);
               req_d   = '{write: pwrite, err: dec_err, mapped: dec_mapped,
                           idx: dec_idx, wdata: pwdata, strb: pstrb};
               if (WAIT_STATES == 0) begin
                  pready_d  = 1'b1;
                  pslverr_d = dec_err;
                  prdata_d  = (!pwrite && !dec_err && dec_mapped) ? rd_dat : '0;
               end
            end
         end
         S_ACCESS: begin
            if (!psel) begin
               state_d   = S_IDLE;
               pready_d  = 1'b0;
               prdata_d  = '0;
               pslverr_d = 1'b0;
            end else if (penable) begin
               if (pready_q) begin
                  if (req_q.write && !req_q.err && req_q.mapped) begin
                     for (int i = 0; i < NUM_REGS; i++) begin
                        if (req_q.idx == ADDR_WIDTH'(i)) begin
                           for (int b = 0; b < STRB_WIDTH; b++) begin
                              if (req_q.strb[b]) regfile_d[i][8*b +: 8] = req_q.wdata[8*b +: 8];
                           end
                        end
                     end
                  end
                  state_d   = S_IDLE;
                  pready_d  = 1'b0;
                  prdata_d  = '0;
                  pslverr_d = 1'b0;
               end else begin
                  cnt_d = cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     pready_d  = 1'b1;
                     pslverr_d = req_q.err;
                     prdata_d  = (!req_q.write && !req_q.err && req_q.mapped) ? rd_dat : '0;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         req_q     <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regfile_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
         regfile_q <= regfile_d;
      end
   end

   assign pready  = pready_q;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regfile_q[g];
   end

endmodule

// File: tb/tb_apb_completer_regbank.sv
// Bench for apb_completer_regbank: three instances with different wait/priv/unmapped settings share one APB bus.
// Expected responses are queued when a transfer is issued and compared when pready rises.
module tb_apb_completer_regbank;
   localparam int          NR       = 16;
   localparam int          WS_P [3] = '{0, 3, 2};
   localparam logic [15:0] PM_P [3] = '{16'h0000, 16'h0001, 16'h0000};
   localparam int          EOU_P[3] = '{1, 1, 0};

   logic        pclk = 1'b0;
   logic        preset_n;
   logic [11:0] paddr;
   logic [2:0]  pprot;
   logic [2:0]  psel_v;
   logic        penable, pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready_w  [3];
   logic [31:0] prdata_w  [3];
   logic        pslverr_w [3];
   logic [511:0] reg_q_w  [3];

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb_q [$];
   logic [31:0] mdl [3][NR];
   int          n_chk = 0;
   int          n_bad = 0;

   always #5 pclk = ~pclk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_completer_regbank #(
         .ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REGS(NR), .WAIT_STATES(WS_P[g]),
         .PRIV_MASK(PM_P[g]), .ERR_ON_UNMAPPED(EOU_P[g])
      ) u_dut (
         .pclk(pclk), .preset_n(preset_n), .paddr(paddr), .pprot(pprot),
         .psel(psel_v[g]), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
         .pstrb(pstrb), .pready(pready_w[g]), .prdata(prdata_w[g]),
         .pslverr(pslverr_w[g]), .reg_q(reg_q_w[g])
      );
   end

   task automatic chk_val(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] mdl_flat(input int d);
      logic [511:0] f;
      for (int i = 0; i < NR; i++) f[i*32 +: 32] = mdl[d][i];
      return f;
   endfunction

   task automatic mdl_clear();
      for (int d = 0; d < 3; d++)
         for (int i = 0; i < NR; i++) mdl[d][i] = '0;
   endtask

   task automatic apb_xfer(input int d, input logic [11:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr);
      exp_t e;
      int   idx, waits;
      bit   mapped, err, got;
      idx    = int'(addr >> 2);
      mapped = idx < NR;
      err    = (addr[1:0] != 2'b00) || (mapped && PM_P[d][idx] && !pr[0]) || (!mapped && EOU_P[d] != 0);
      e.err   = err;
      e.rdata = (!wr && !err && mapped) ? mdl[d][idx] : 32'h0;
      sb_q.push_back(e);

      @(negedge pclk);
      paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; pprot = pr;
      penable = 1'b0; psel_v[d] = 1'b1;
      @(negedge pclk);
      penable = 1'b1;
      waits = 0;
      got   = 0;
      while (!got && waits <= 20) begin
         if (pready_w[d] === 1'b1) got = 1;
         else begin
            if (wr && mapped) chk_val("hold", reg_q_w[d][idx*32 +: 32], mdl[d][idx]);
            waits++;
            @(negedge pclk);
         end
      end
      if (!got) chk_val("timeout", pready_w[d], 1);
      e = sb_q.pop_front();
      chk_val("prdata", prdata_w[d], e.rdata);
      chk_val("pslverr", pslverr_w[d], e.err);
      chk_val("waits", waits, WS_P[d]);

      @(negedge pclk);
      psel_v[d] = 1'b0;
      penable   = 1'b0;
      if (wr && !err && mapped)
         for (int b = 0; b < 4; b++)
            if (st[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
      chk_val("rdy_clr", pready_w[d], 0);
      chk_val("rdat_clr", prdata_w[d], 0);
      chk_val("regq", reg_q_w[d], mdl_flat(d));
   endtask

   task automatic apb_abort(input int d, input logic [11:0] addr, input logic [31:0] wd);
      @(negedge pclk);
      paddr = addr; pwrite = 1'b1; pwdata = wd; pstrb = 4'hF; pprot = 3'b001;
      penable = 1'b0; psel_v[d] = 1'b1;
      @(negedge pclk);
      penable = 1'b1;
      chk_val("ab_wait", pready_w[d], 0);
      @(negedge pclk);
      psel_v[d] = 1'b0;
      penable   = 1'b0;
      repeat (3) begin
         @(negedge pclk);
         chk_val("ab_rdy", pready_w[d], 0);
      end
      chk_val("ab_regq", reg_q_w[d], mdl_flat(d));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running want done");
      $fatal(1);
   end

   initial begin
      int d;
      logic [11:0] a;
      preset_n = 1'b0;
      psel_v = '0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      mdl_clear();
      repeat (2) @(negedge pclk);
      for (int k = 0; k < 3; k++) begin
         chk_val("rst_rdy", pready_w[k], 0);
         chk_val("rst_rdat", prdata_w[k], 0);
         chk_val("rst_err", pslverr_w[k], 0);
         chk_val("rst_regq", reg_q_w[k], 0);
      end
      preset_n = 1'b1;

      apb_xfer(0, 12'h00C, 1'b0, 32'h0, 4'h0, 3'b000);
      apb_xfer(0, 12'h004, 1'b1, 32'hDEADBEEF, 4'b1111, 3'b000);
      apb_xfer(0, 12'h004, 1'b1, 32'h11223344, 4'b0101, 3'b000);
      apb_xfer(0, 12'h004, 1'b0, 32'h0, 4'h0, 3'b000);
      chk_val("r1_const", reg_q_w[0][63:32], 32'hDE22BE44);
      apb_xfer(0, 12'h002, 1'b0, 32'h0, 4'h0, 3'b000);
      apb_xfer(0, 12'h040, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000);
      apb_xfer(2, 12'h040, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000);
      apb_xfer(2, 12'h040, 1'b0, 32'h0, 4'h0, 3'b000);

      apb_xfer(1, 12'h008, 1'b1, 32'h0BADF00D, 4'hF, 3'b000);
      apb_xfer(1, 12'h000, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b000);
      apb_xfer(1, 12'h000, 1'b1, 32'hA5A5A5A5, 4'hF, 3'b001);
      chk_val("priv_const", reg_q_w[1][31:0], 32'hA5A5A5A5);
      apb_xfer(1, 12'h000, 1'b0, 32'h0, 4'h0, 3'b000);
      apb_xfer(1, 12'h000, 1'b0, 32'h0, 4'h0, 3'b001);

      for (int k = 0; k < 24; k++) begin
         d = k % 3;
         a = 12'($urandom_range(0, 80));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         apb_xfer(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 1)));
      end

      apb_xfer(2, 12'h010, 1'b1, 32'h12345678, 4'hF, 3'b000);
      apb_abort(2, 12'h010, 32'hFFFFFFFF);
      apb_xfer(2, 12'h010, 1'b0, 32'h0, 4'h0, 3'b000);

      @(negedge pclk);
      paddr = 12'h014; pwrite = 1'b1; pwdata = 32'h55AA55AA; pstrb = 4'hF; pprot = 3'b000;
      penable = 1'b0; psel_v[2] = 1'b1;
      @(negedge pclk);
      penable = 1'b1;
      #2 preset_n = 1'b0;
      #1;
      mdl_clear();
      chk_val("mr_rdy", pready_w[2], 0);
      chk_val("mr_rdat", prdata_w[2], 0);
      chk_val("mr_err", pslverr_w[2], 0);
      chk_val("mr_regq2", reg_q_w[2], 0);
      chk_val("mr_regq0", reg_q_w[0], 0);
      psel_v = '0;
      penable = 1'b0;
      @(negedge pclk);
      preset_n = 1'b1;
      apb_xfer(2, 12'h010, 1'b0, 32'h0, 4'h0, 3'b000);
      apb_xfer(2, 12'h014, 1'b0, 32'h0, 4'h0, 3'b000);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
